// File: rtl/popcount_accum_ctrl.sv
// Job sequencer around a shared 32-bit popcount datapath: streams num_words
// words through the counter, accumulates the per-word counts, returns the total.

module popcount_int32 (
  input  logic [31:0] data,
  output logic [5:0]  count
);

  // Two-level adder tree: nibble counts, then a sum of the eight nibble counts.
  logic [2:0] nib [8];

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      nib[n] = 3'(data[4*n]) + 3'(data[4*n+1]) + 3'(data[4*n+2]) + 3'(data[4*n+3]);
    end
    count = 6'(nib[0]) + 6'(nib[1]) + 6'(nib[2]) + 6'(nib[3])
          + 6'(nib[4]) + 6'(nib[5]) + 6'(nib[6]) + 6'(nib[7]);
  end

endmodule

module popcount_accum_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_words,
  output logic                 busy,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNT_W+6-1:0]   res_sum
);

  localparam int unsigned ACC_W = CNT_W + 6;
  localparam int unsigned PC_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   remaining_q;
  logic [ACC_W-1:0]   acc_q;
  logic [PC_W-1:0]    pcnt_q;
  logic               pcnt_vld_q;
  logic               busy_q;
  logic               in_ready_q;
  logic               res_valid_q;

  logic [PC_W-1:0]    pcnt_c;
  logic               job_start_c;
  logic               word_accept_c;

  popcount_int32 u_popcount (
    .data  (in_data),
    .count (pcnt_c)
  );

  // Handshake qualifiers use the registered state only, never the outputs.
  assign job_start_c   = (state_q == IDLE) && start;
  assign word_accept_c = (state_q == RUN) && in_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid && (remaining_q == CNT_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are registered copies of the next-state decode, so each one
  // tracks the state register exactly while coming straight off a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      busy_q      <= (state_d != IDLE);
      in_ready_q  <= (state_d == RUN);
      res_valid_q <= (state_d == DONE);
    end
  end

  // Word counter and per-word popcount pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= '0;
      pcnt_q      <= '0;
      pcnt_vld_q  <= 1'b0;
    end else begin
      pcnt_vld_q <= word_accept_c;
      if (job_start_c) begin
        remaining_q <= num_words;
      end else if (word_accept_c) begin
        remaining_q <= remaining_q - CNT_W'(1);
      end
      if (word_accept_c) begin
        pcnt_q <= pcnt_c;
      end
    end
  end

  // Accumulator: cleared by a new job, otherwise folds in each staged count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (job_start_c) begin
      acc_q <= '0;
    end else if (pcnt_vld_q) begin
      acc_q <= acc_q + ACC_W'(pcnt_q);
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_sum   = acc_q;

endmodule

// File: tb/tb_popcount_accum_ctrl.sv
// Scoreboard bench for popcount_accum_ctrl: expected job totals are queued at
// job issue and checked by a monitor on every result handshake.

module tb_popcount_accum_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ACC_W = CNT_W + 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_words = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [ACC_W-1:0] res_sum;

  int n_checks = 0;
  int n_fail   = 0;
  longint exp_q[$];

  int cyc = 0;
  int ir_cnt = 0;
  int last_acc_cyc = -1;
  int start_cyc = -1;
  int rise_cyc = -1;
  bit rv_prev = 1'b0;

  popcount_accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: event bookkeeping and scoreboard comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (in_ready) ir_cnt++;
    if (in_valid && in_ready) last_acc_cyc = cyc;
    if (start && !busy && !rst) start_cyc = cyc;
    if (res_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = res_valid;
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(res_sum), -1);
      end else begin
        check("res_sum", 64'(res_sum), exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin step(); t++; end
    if (busy) check("timeout_idle", 0, 1);
  endtask

  // Issue a job whose expected total is computed from the word list.
  task automatic issue_job(input int n, input logic [WIDTH-1:0] words[$]);
    longint s = 0;
    foreach (words[i]) s += $countones(words[i]);
    exp_q.push_back(s);
    start = 1'b1;
    num_words = CNT_W'(n);
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input int gap);
    bit hs = 1'b0;
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data = d;
    while (!hs && t < 300) begin
      @(negedge clk);
      hs = in_ready;
      step();
      t++;
    end
    in_valid = 1'b0;
    if (!hs) check("timeout_accept", 0, 1);
  endtask

  task automatic send_all(input logic [WIDTH-1:0] words[$]);
    foreach (words[i]) send_word(words[i], 0);
  endtask

  initial begin
    logic [WIDTH-1:0] w[$];
    int base;

    // Reset state
    #3;
    check("reset_busy", 64'(busy), 0);
    check("reset_in_ready", 64'(in_ready), 0);
    check("reset_res_valid", 64'(res_valid), 0);
    check("reset_res_sum", 64'(res_sum), 0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: single all-ones word, latency accept -> res_valid is 2 cycles
    w = {32'hFFFF_FFFF};
    issue_job(1, w);
    send_all(w);
    wait_idle();
    check("t1_latency", 64'(rise_cyc - last_acc_cyc), 2);

    // 2: four back-to-back words, in_ready high for exactly 4 cycles
    w = {32'h0000_0000, 32'h0000_0001, 32'h8000_0001, 32'hF0F0_F0F0};
    base = ir_cnt;
    issue_job(4, w);
    send_all(w);
    wait_idle();
    check("t2_in_ready_cycles", 64'(ir_cnt - base), 4);
    check("t2_total", 64'(res_sum), 19);

    // 3: empty job
    w = {};
    base = ir_cnt;
    issue_job(0, w);
    wait_idle();
    check("t3_latency", 64'(rise_cyc - start_cyc), 1);
    check("t3_in_ready_cycles", 64'(ir_cnt - base), 0);

    // 4: input gaps, result held by res_ready=0, start during DONE ignored
    w = {32'h0000_000F, 32'h0000_000F, 32'h0000_000F};
    res_ready = 1'b0;
    issue_job(3, w);
    send_word(w[0], 0);
    send_word(w[1], 2);
    send_word(w[2], 1);
    step(); step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(res_valid), 1);
      check("t4_hold_sum", 64'(res_sum), 12);
      if (k == 1) begin
        step();
        start = 1'b1;
        num_words = CNT_W'(7);
      end else begin
        step();
        start = 1'b0;
      end
    end
    check("t4_busy_in_done", 64'(busy), 1);
    res_ready = 1'b1;
    step();
    check("t4_idle_after_done", 64'(busy), 0);
    step();
    check("t4_no_new_job", 64'(busy), 0);
    check("t4_sum_retained", 64'(res_sum), 12);

    // 5: reset mid-job discards it; next job starts clean
    w = {32'h1, 32'h3, 32'h7, 32'hF};
    issue_job(4, w);
    send_word(w[0], 0);
    send_word(w[1], 0);
    rst = 1'b1;
    #2;
    check("t5_rst_busy", 64'(busy), 0);
    check("t5_rst_in_ready", 64'(in_ready), 0);
    check("t5_rst_res_valid", 64'(res_valid), 0);
    check("t5_rst_res_sum", 64'(res_sum), 0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    w = {32'h0000_0003, 32'h0000_0003};
    issue_job(2, w);
    send_all(w);
    wait_idle();
    check("t5_clean_total", 64'(res_sum), 4);

    // Random jobs with random gaps and result back-pressure
    for (int j = 0; j < 8; j++) begin
      int n = $urandom_range(1, 12);
      int hold = $urandom_range(0, 3);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom());
      res_ready = (hold == 0);
      issue_job(n, w);
      foreach (w[i]) send_word(w[i], $urandom_range(0, 2));
      begin
        int t = 0;
        while (!res_valid && t < 50) begin step(); t++; end
        if (!res_valid) check("timeout_result", 0, 1);
      end
      repeat (hold) step();
      res_ready = 1'b1;
      wait_idle();
    end

    // 6: maximum-length job of all-ones words
    w = {};
    for (int i = 0; i < 65535; i++) w.push_back(32'hFFFF_FFFF);
    issue_job(65535, w);
    send_all(w);
    wait_idle();
    check("t6_max_total", 64'(res_sum), 2097120);

    step();
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
